game_sequencer: RTL and testbench

- Top-level game controller for the VGA game.
- Watches the pixel scan position (x, y) and the per-pixel object flags (player_on, enemy_on) to detect player/enemy collisions.
- Runs the game state machine and tracks score and lives.
- Drives game_state, p1_score, player_dead, enemy_rst and led to the render, enemy and player blocks.

---
 rtl/game_sequencer.sv | 146 ++++++++++++++
 tb/tb_game_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game controller: button sync, frame tick, collision latch, PLAY/DEAD/OVER FSM, score and lives.
// Optional GAME_HISCORE_EN adds a hi_score register that is updated on each game over.
module game_sequencer #(
  parameter int unsigned FRAME_Y      = 480,
  parameter int unsigned SCORE_FRAMES = 60,
  parameter int unsigned DEAD_FRAMES  = 120,
  parameter int unsigned LIVES        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        player_on,
  input  logic        enemy_on,
  output logic [1:0]  game_state,
  output logic [3:0]  p1_score,
  output logic [2:0]  lives,
  output logic        player_dead,
  output logic        enemy_rst,
  output logic        led
`ifdef GAME_HISCORE_EN
  ,
  output logic [3:0]  hi_score
`endif
);

  localparam int unsigned FW = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam int unsigned DW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
  localparam logic [FW-1:0] ScoreLast = FW'(SCORE_FRAMES - 1);
  localparam logic [DW-1:0] DeadLast  = DW'(DEAD_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StDead = 2'b10,
    StOver = 2'b11
  } state_e;

  state_e          state_q;
  logic [FW-1:0]   frame_cnt;
  logic [DW-1:0]   dead_cnt;
  logic            btn_meta, btn_sync, btn_q;
  logic            cond, cond_q, frame_tick, start_p;
  logic            hit_q;

  assign cond       = (x == 16'd0) && (y == 16'(FRAME_Y));
  assign frame_tick = cond & ~cond_q;
  assign start_p    = btn_sync & ~btn_q;
  assign game_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_q    <= 1'b0;
      cond_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      btn_q    <= btn_sync;
      cond_q   <= cond;
      // Clearing wins over a same-cycle overlap; PLAY is only left on a tick.
      if (state_q != StPlay || frame_tick) begin
        hit_q <= 1'b0;
      end else if (player_on && enemy_on) begin
        hit_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      p1_score    <= 4'd0;
      lives       <= 3'd0;
      frame_cnt   <= '0;
      dead_cnt    <= '0;
      player_dead <= 1'b0;
      enemy_rst   <= 1'b0;
      led         <= 1'b0;
`ifdef GAME_HISCORE_EN
      hi_score    <= 4'd0;
`endif
    end else begin
      enemy_rst <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_p) begin
            state_q   <= StPlay;
            lives     <= 3'(LIVES);
            p1_score  <= 4'd0;
            frame_cnt <= '0;
            enemy_rst <= 1'b1;
          end
        end
        StPlay: begin
          if (frame_tick) begin
            if (hit_q) begin
              state_q     <= StDead;
              lives       <= lives - 3'd1;
              dead_cnt    <= '0;
              frame_cnt   <= '0;
              player_dead <= 1'b1;
            end else if (frame_cnt == ScoreLast) begin
              frame_cnt <= '0;
              if (p1_score != 4'hf) p1_score <= p1_score + 4'd1;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
        end
        StDead: begin
          if (frame_tick) begin
            if (dead_cnt == DeadLast) begin
              player_dead <= 1'b0;
              dead_cnt    <= '0;
              if (lives == 3'd0) begin
                state_q <= StOver;
                led     <= 1'b1;
`ifdef GAME_HISCORE_EN
                if (p1_score > hi_score) hi_score <= p1_score;
`endif
              end else begin
                state_q   <= StPlay;
                enemy_rst <= 1'b1;
                frame_cnt <= '0;
              end
            end else begin
              dead_cnt <= dead_cnt + DW'(1);
            end
          end
        end
        StOver: begin
          if (start_p) begin
            state_q <= StIdle;
            led     <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: step table for the game flow plus an enemy_rst pulse scoreboard.
module tb_game_sequencer;

  localparam int unsigned FY = 4;
  localparam int W = 4;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        reset, button, player_on, enemy_on;
  logic [15:0] x, y;
  logic [1:0]  game_state;
  logic [3:0]  p1_score;
  logic [2:0]  lives;
  logic        player_dead, enemy_rst, led;
`ifdef GAME_HISCORE_EN
  logic [3:0]  hi_score;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int lives;
    int score;
  } pulse_t;
  pulse_t sb_q[$];

  typedef struct {
    string name;
    int    kind;     // 0: run frames, 1: button press
    int    n;
    bit    collide;
    bit    pulse;
    int    st;
    int    score;
    int    lives;
    int    pd;
    int    led;
  } step_t;
  step_t steps[13];

  game_sequencer #(
    .FRAME_Y(FY),
    .SCORE_FRAMES(2),
    .DEAD_FRAMES(3),
    .LIVES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .x(x),
    .y(y),
    .player_on(player_on),
    .enemy_on(enemy_on),
    .game_state(game_state),
    .p1_score(p1_score),
    .lives(lives),
    .player_dead(player_dead),
    .enemy_rst(enemy_rst),
    .led(led)
`ifdef GAME_HISCORE_EN
    ,
    .hi_score(hi_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each pixel is held two clocks; one frame ends with exactly one tick at (0, FY).
  task automatic run_frames(input int n, input bit collide);
    for (int f = 0; f < n; f++) begin
      for (int yy = 0; yy < H; yy++) begin
        for (int xx = 0; xx < W; xx++) begin
          x = 16'(xx);
          y = 16'(yy);
          player_on = collide && (f == 0) && (xx == 2) && (yy == 1);
          enemy_on  = player_on;
          cyc(2);
        end
      end
    end
    player_on = 1'b0;
    enemy_on  = 1'b0;
    x = 16'd0;
    y = 16'd0;
  endtask

  task automatic press(input int hold);
    button = 1'b1;
    cyc(hold);
    button = 1'b0;
    cyc(6);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic push(input int l, input int s);
    pulse_t p;
    p.lives = l;
    p.score = s;
    sb_q.push_back(p);
  endtask

  task automatic check_outputs(input string tag, input int st, input int sc, input int lv,
                               input int pd, input int ld);
    check({tag, "_state"}, int'(game_state), st);
    check({tag, "_score"}, int'(p1_score), sc);
    check({tag, "_lives"}, int'(lives), lv);
    check({tag, "_player_dead"}, int'(player_dead), pd);
    check({tag, "_led"}, int'(led), ld);
    check({tag, "_enemy_rst"}, int'(enemy_rst), 0);
  endtask

  always @(negedge clk) begin
    if (enemy_rst === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("enemy_rst_unexpected", int'(enemy_rst), 0);
      end else begin
        pulse_t p;
        p = sb_q.pop_front();
        check("pulse_state", int'(game_state), 1);
        check("pulse_lives", int'(lives), p.lives);
        check("pulse_score", int'(p1_score), p.score);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    steps[0]  = '{"start_hold",  1, 50, 0, 1, 1,  0, 2, 0, 0};
    steps[1]  = '{"play6",       0,  6, 0, 0, 1,  3, 2, 0, 0};
    steps[2]  = '{"play40",      0, 34, 0, 0, 1, 15, 2, 0, 0};
    steps[3]  = '{"press_play",  1,  5, 0, 0, 1, 15, 2, 0, 0};
    steps[4]  = '{"collide1",    0,  1, 1, 0, 2, 15, 1, 1, 0};
    steps[5]  = '{"dead_wait",   0,  2, 0, 0, 2, 15, 1, 1, 0};
    steps[6]  = '{"press_dead",  1,  5, 0, 0, 2, 15, 1, 1, 0};
    steps[7]  = '{"respawn",     0,  1, 0, 1, 1, 15, 1, 0, 0};
    steps[8]  = '{"collide2",    0,  1, 1, 0, 2, 15, 0, 1, 0};
    steps[9]  = '{"game_over",   0,  3, 0, 0, 3, 15, 0, 0, 1};
    steps[10] = '{"over_press",  1,  5, 0, 0, 0, 15, 0, 0, 0};
    steps[11] = '{"restart",     1,  5, 0, 1, 1,  0, 2, 0, 0};
    steps[12] = '{"replay3",     0,  3, 0, 0, 1,  1, 2, 0, 0};

    reset = 1'b1;
    button = 1'b0;
    player_on = 1'b0;
    enemy_on = 1'b0;
    x = 16'd0;
    y = 16'd0;
    cyc(3);
    @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(2);

    // Reset asserted in the middle of a frame while playing with score 3.
    push(2, 0);
    press(5);
    run_frames(6, 1'b0);
    @(negedge clk);
    check("pre_reset_score", int'(p1_score), 3);
    x = 16'd1;
    y = 16'd2;
    cyc(1);
    reset = 1'b1;
    #1;
    check("async_reset_state", int'(game_state), 0);
    @(negedge clk);
    check_outputs("mid_reset", 0, 0, 0, 0, 0);
    cyc(1);
    reset = 1'b0;
    x = 16'd0;
    y = 16'd0;
    cyc(2);

    for (int i = 0; i < 13; i++) begin
      if (steps[i].pulse) push(steps[i].lives, steps[i].score);
      if (steps[i].kind == 1) press(steps[i].n);
      else run_frames(steps[i].n, steps[i].collide);
      @(negedge clk);
      check_outputs(steps[i].name, steps[i].st, steps[i].score, steps[i].lives,
                    steps[i].pd, steps[i].led);
    end

`ifdef GAME_HISCORE_EN
    do_reset();
    check("hi_after_reset0", int'(hi_score), 0);
    push(2, 0);
    press(5);
    run_frames(10, 1'b0);
    run_frames(1, 1'b1);
    push(1, 5);
    run_frames(3, 1'b0);
    run_frames(1, 1'b1);
    run_frames(3, 1'b0);
    @(negedge clk);
    check("g1_state", int'(game_state), 3);
    check("g1_hi", int'(hi_score), 5);
    press(5);
    push(2, 0);
    press(5);
    run_frames(4, 1'b0);
    run_frames(1, 1'b1);
    push(1, 2);
    run_frames(3, 1'b0);
    run_frames(1, 1'b1);
    run_frames(3, 1'b0);
    @(negedge clk);
    check("g2_state", int'(game_state), 3);
    check("g2_score", int'(p1_score), 2);
    check("g2_hi", int'(hi_score), 5);
    do_reset();
    @(negedge clk);
    check("hi_after_reset", int'(hi_score), 0);
`endif

    cyc(4);
    check("sb_pending", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
